// File: rtl/mult_acc_pkg.sv
// Shared types and default widths for the product accumulator.
package mult_acc_pkg;

  localparam int DEF_PROD_W = 64;
  localparam int DEF_ACC_W  = 72;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/acc_sat_add.sv
// Sign-extending accumulator adder with overflow detect.
// MULT_ACC_SAT_EN selects saturation instead of wrap on overflow.
module acc_sat_add
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] sum_ext;

  assign acc_ext  = {acc[ACC_W-1], acc};
  assign prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum_ext  = acc_ext + prod_ext;
  // Extra guard bit carries the true sign; disagreement means overflow.
  assign ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

`ifdef MULT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  always_comb begin
    sum = sum_ext[ACC_W-1:0];
    if (ovf) sum = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
  end
`else
  assign sum = sum_ext[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Sums a programmed number of signed products with valid/ready in and out.
// Optional saturation via MULT_ACC_SAT_EN (see acc_sat_add).
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting products until len_q have transferred
// DONE  | result presented, held until res_ready
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              ovf
);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ACC_W-1:0]  sum;
  logic              add_ovf;

  acc_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc  (acc),
    .prod (prod),
    .sum  (sum),
    .ovf  (add_ovf)
  );

  assign prod_ready = (state == ACCUM);
  // acc is frozen outside ACCUM, so it doubles as the held result.
  assign res        = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            if (len != '0) begin
              state <= ACCUM;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc <= sum;
            cnt <= cnt + LEN_W'(1);
            if (add_ovf) ovf <= 1'b1;
            if (cnt == len_q - LEN_W'(1)) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed scoreboard bench for mult_accumulator, built with ACC_W=64.
module tb_mult_accumulator;

  localparam int PW = 64;
  localparam int AW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic [PW-1:0] prod;
  logic          prod_valid;
  logic          prod_ready;
  logic [AW-1:0] res;
  logic          res_valid;
  logic          res_ready;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] res;
    logic          ovf;
  } exp_t;

  exp_t sb[$];

  mult_accumulator #(
    .PROD_W (PW),
    .ACC_W  (AW),
    .LEN_W  (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .res        (res),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, req);
    end
  endtask

  task automatic checkw(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [LW-1:0] l, input logic [AW-1:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    sb.push_back(e);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic xfer(input logic [PW-1:0] p);
    int t;
    t          = 0;
    prod       = p;
    prod_valid = 1'b1;
    while (!prod_ready && t < 50) begin
      tick();
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL xfer_timeout: got prod_ready=0 for %0d cycles expected 1", t);
    end
    tick();
    prod_valid = 1'b0;
  endtask

  // Monitor: every result handshake is compared against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res=%0h expected no result", res);
      end else begin
        e = sb.pop_front();
        checkw("sb_res", res, e.res);
        check1("sb_ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    len        = '0;
    prod       = '0;
    prod_valid = 1'b0;
    res_ready  = 1'b1;
    #12;
    check1("rst_busy", busy, 1'b0);
    check1("rst_res_valid", res_valid, 1'b0);
    check1("rst_prod_ready", prod_ready, 1'b0);
    check1("rst_ovf", ovf, 1'b0);
    checkw("rst_res", res, '0);
    tick();
    rst = 1'b0;
    tick();

    // Basic sum: 6 - 20 + 1000 = 986
    start_run(8'd3, 64'sd986, 1'b0);
    check1("basic_prod_ready", prod_ready, 1'b1);
    xfer(64'sd6);
    xfer(-64'sd20);
    xfer(64'sd1000);
    check1("basic_latency", res_valid, 1'b1);
    tick();
    check1("basic_idle", busy, 1'b0);
    check1("basic_valid_drop", res_valid, 1'b0);

    // Input stalls: only valid cycles count
    start_run(8'd2, 64'sd12, 1'b0);
    prod = 64'sd5; prod_valid = 1'b1; tick();
    prod = 64'sd999; prod_valid = 1'b0; tick(); tick();
    check1("stall_no_done", res_valid, 1'b0);
    prod = 64'sd7; prod_valid = 1'b1; tick();
    prod_valid = 1'b0;
    check1("stall_done", res_valid, 1'b1);
    tick();

    // Output backpressure with ignored start pulses
    res_ready = 1'b0;
    start_run(8'd1, 64'sd42, 1'b0);
    xfer(64'sd42);
    for (int i = 0; i < 5; i++) begin
      check1("bp_res_valid", res_valid, 1'b1);
      check1("bp_prod_ready", prod_ready, 1'b0);
      checkw("bp_res", res, 64'd42);
      start = 1'b1;
      len   = 8'd3;
      tick();
      start = 1'b0;
    end
    res_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check1("bp_idle", busy, 1'b0);
    check1("bp_valid_drop", res_valid, 1'b0);
    tick();
    check1("bp_start_ignored", busy, 1'b0);

    // Zero-length run
    start_run(8'd0, 64'd0, 1'b0);
    check1("zero_res_valid", res_valid, 1'b1);
    check1("zero_prod_ready", prod_ready, 1'b0);
    tick();
    check1("zero_idle", busy, 1'b0);

    // Overflow at ACC_W=64
`ifdef MULT_ACC_SAT_EN
    start_run(8'd2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
`else
    start_run(8'd2, 64'h8000_0000_0000_0000, 1'b1);
`endif
    xfer(64'h7FFF_FFFF_FFFF_FFFF);
    xfer(64'sd1);
    tick();
    // Sticky ovf clears on the next accepted start
    start_run(8'd1, 64'sd3, 1'b0);
    xfer(64'sd3);
    tick();

    // Reset mid-run discards the partial sum
    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    xfer(64'sd100);
    rst = 1'b1;
    #1;
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_res_valid", res_valid, 1'b0);
    check1("mid_rst_prod_ready", prod_ready, 1'b0);
    checkw("mid_rst_acc", res, '0);
    tick();
    rst = 1'b0;
    tick();
    start_run(8'd1, -64'sd9, 1'b0);
    xfer(-64'sd9);
    tick();

    for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
    check1("sb_drained", sb.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
